// File: rtl/avmm_initiator_if.sv
// Command, response and Avalon-MM master signal bundle for avmm_initiator.
// master is the initiator side; slave is the environment driving it.
interface avmm_initiator_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;

    logic [ADDR_WIDTH-1:0] avalon_address;
    logic                  avalon_write;
    logic                  avalon_read;
    logic [DATA_WIDTH-1:0] avalon_writedata;
    logic [DATA_WIDTH-1:0] avalon_readdata;
    logic                  avalon_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        input  rsp_ready,
        output avalon_address, avalon_write, avalon_read,
        output avalon_writedata,
        input  avalon_readdata, avalon_waitrequest
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        output rsp_ready,
        input  avalon_address, avalon_write, avalon_read,
        input  avalon_writedata,
        output avalon_readdata, avalon_waitrequest
    );
endinterface

// File: rtl/avmm_initiator.sv
// Single-outstanding Avalon-MM initiator: command stream in, response out,
// with waitrequest timeout and fixed read latency.
module avmm_initiator #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    avmm_initiator_if.master bus,
    output logic             busy
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT_DATA,
        RESP
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LAT          = 3'(READ_LATENCY);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [2:0]  lat_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            wait_cnt             <= '0;
            lat_cnt              <= '0;
            busy                 <= 1'b0;
            bus.cmd_ready        <= 1'b1;
            bus.rsp_valid        <= 1'b0;
            bus.rsp_rdata        <= {DATA_WIDTH{1'b0}};
            bus.rsp_error        <= 1'b0;
            bus.avalon_address   <= {ADDR_WIDTH{1'b0}};
            bus.avalon_write     <= 1'b0;
            bus.avalon_read      <= 1'b0;
            bus.avalon_writedata <= {DATA_WIDTH{1'b0}};
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.avalon_address   <= bus.cmd_addr;
                        bus.avalon_writedata <= bus.cmd_wdata;
                        bus.avalon_write     <= bus.cmd_write;
                        bus.avalon_read      <= !bus.cmd_write;
                        bus.cmd_ready        <= 1'b0;
                        busy                 <= 1'b1;
                        wait_cnt             <= '0;
                        state <= bus.cmd_write ? WRITE : READ;
                    end
                end
                WRITE, READ: begin
                    if (bus.avalon_waitrequest) begin
                        // Abort on the last permitted stalled cycle
                        if (wait_cnt == TIMEOUT_LAST) begin
                            bus.avalon_address   <= {ADDR_WIDTH{1'b0}};
                            bus.avalon_writedata <= {DATA_WIDTH{1'b0}};
                            bus.avalon_write     <= 1'b0;
                            bus.avalon_read      <= 1'b0;
                            bus.rsp_valid        <= 1'b1;
                            bus.rsp_rdata        <= {DATA_WIDTH{1'b0}};
                            bus.rsp_error        <= 1'b1;
                            state                <= RESP;
                        end else if (wait_cnt != 16'hFFFF) begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end else begin
                        bus.avalon_address   <= {ADDR_WIDTH{1'b0}};
                        bus.avalon_writedata <= {DATA_WIDTH{1'b0}};
                        bus.avalon_write     <= 1'b0;
                        bus.avalon_read      <= 1'b0;
                        if (state == WRITE) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
                            bus.rsp_error <= 1'b0;
                            state         <= RESP;
                        end else begin
                            lat_cnt <= LAT;
                            state   <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (lat_cnt == 3'd1) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= bus.avalon_readdata;
                        bus.rsp_error <= 1'b0;
                        state         <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
                        bus.rsp_error <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avmm_initiator.sv
// Directed bench for avmm_initiator (READ_LATENCY=1, TIMEOUT_CYCLES=4).
module tb_avmm_initiator;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    avmm_initiator_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    avmm_initiator #(
        .ADDR_WIDTH    (4),
        .DATA_WIDTH    (32),
        .READ_LATENCY  (1),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    wire [37:0] av = {bus.avalon_write, bus.avalon_read,
                      bus.avalon_address, bus.avalon_writedata};
    wire [33:0] rs = {bus.rsp_valid, bus.rsp_error, bus.rsp_rdata};
    wire [1:0]  ctl = {bus.cmd_ready, busy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++; if (ctl !== 2'b10) begin bad++; $display("FAIL rst_ctl got=%b exp=10", ctl); end
        total++; if (av !== 38'd0) begin bad++; $display("FAIL rst_av got=%h exp=0", av); end
        total++; if (rs !== 34'd0) begin bad++; $display("FAIL rst_rs got=%h exp=0", rs); end
    endtask

    task automatic test_write();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
        bus.cmd_addr = 4'd3; bus.cmd_wdata = 32'h0000_00A5;
        step();
        bus.cmd_valid = 1'b0;
        total++; if (av !== {1'b1, 1'b0, 4'd3, 32'hA5}) begin bad++; $display("FAIL wr_av got=%h", av); end
        total++; if (ctl !== 2'b01) begin bad++; $display("FAIL wr_ctl got=%b exp=01", ctl); end
        step();
        total++; if (av !== 38'd0) begin bad++; $display("FAIL wr_av_done got=%h exp=0", av); end
        total++; if (rs !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL wr_rsp got=%h", rs); end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        total++; if (rs !== 34'd0) begin bad++; $display("FAIL wr_rsp_end got=%h exp=0", rs); end
        total++; if (ctl !== 2'b10) begin bad++; $display("FAIL wr_idle got=%b exp=10", ctl); end
    endtask

    task automatic test_read();
        bus.avalon_readdata = 32'hDEAD_BEEF;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
        bus.cmd_addr = 4'd0; bus.cmd_wdata = 32'h77;
        step();
        bus.cmd_valid = 1'b0;
        total++; if (av !== {1'b0, 1'b1, 4'd0, 32'h77}) begin bad++; $display("FAIL rd_av got=%h", av); end
        step();
        total++; if (av !== 38'd0) begin bad++; $display("FAIL rd_wait_av got=%h exp=0", av); end
        total++; if (rs !== 34'd0) begin bad++; $display("FAIL rd_wait_rs got=%h exp=0", rs); end
        total++; if (ctl !== 2'b01) begin bad++; $display("FAIL rd_wait_ctl got=%b exp=01", ctl); end
        bus.avalon_readdata = 32'h0000_00A5;
        step();
        bus.avalon_readdata = 32'h1234_5678;
        total++; if (rs !== {1'b1, 1'b0, 32'hA5}) begin bad++; $display("FAIL rd_rsp got=%h", rs); end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        total++; if (rs !== 34'd0) begin bad++; $display("FAIL rd_rsp_end got=%h exp=0", rs); end
    endtask

    task automatic test_stall();
        bus.avalon_waitrequest = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
        bus.cmd_addr = 4'd5; bus.cmd_wdata = 32'h1234_5678;
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (av !== {1'b1, 1'b0, 4'd5, 32'h1234_5678}) begin
                bad++; $display("FAIL stall_av[%0d] got=%h", i, av);
            end
            total++; if (rs !== 34'd0) begin bad++; $display("FAIL stall_rs[%0d] got=%h", i, rs); end
            if (i == 3) bus.avalon_waitrequest = 1'b0;
            step();
        end
        total++; if (av !== 38'd0) begin bad++; $display("FAIL stall_av_done got=%h exp=0", av); end
        total++; if (rs !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL stall_rsp got=%h", rs); end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        step();
        total++; if (rs !== 34'd0) begin bad++; $display("FAIL stall_single got=%h exp=0", rs); end
    endtask

    task automatic test_timeout();
        bus.avalon_readdata = 32'h0;
        bus.avalon_waitrequest = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
        bus.cmd_addr = 4'd9; bus.cmd_wdata = 32'h0;
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (av !== {1'b0, 1'b1, 4'd9, 32'h0}) begin
                bad++; $display("FAIL to_av[%0d] got=%h", i, av);
            end
            step();
        end
        total++; if (av !== 38'd0) begin bad++; $display("FAIL to_drop got=%h exp=0", av); end
        total++; if (rs !== {1'b1, 1'b1, 32'h0}) begin bad++; $display("FAIL to_rsp got=%h", rs); end
        bus.avalon_waitrequest = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        total++; if (ctl !== 2'b10) begin bad++; $display("FAIL to_idle got=%b exp=10", ctl); end
    endtask

    task automatic test_back_to_back();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
        bus.cmd_addr = 4'd7; bus.cmd_wdata = 32'h0;
        step();
        bus.cmd_valid = 1'b0;
        step();
        bus.avalon_readdata = 32'h5A5A_5A5A;
        step();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
        bus.cmd_addr = 4'd1; bus.cmd_wdata = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rs !== {1'b1, 1'b0, 32'h5A5A_5A5A}) begin
                bad++; $display("FAIL bp_rs[%0d] got=%h", i, rs);
            end
            total++; if (ctl !== 2'b01) begin bad++; $display("FAIL bp_ctl[%0d] got=%b exp=01", i, ctl); end
            total++; if (av !== 38'd0) begin bad++; $display("FAIL bp_av[%0d] got=%h exp=0", i, av); end
            bus.avalon_readdata = 32'(i);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        total++; if (ctl !== 2'b10) begin bad++; $display("FAIL b2b_gap_ctl got=%b exp=10", ctl); end
        total++; if (av !== 38'd0) begin bad++; $display("FAIL b2b_gap_av got=%h exp=0", av); end
        step();
        bus.cmd_valid = 1'b0;
        total++;
        if (av !== {1'b1, 1'b0, 4'd1, 32'h0BAD_F00D}) begin
            bad++; $display("FAIL b2b_wr got=%h", av);
        end
        step();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.avalon_waitrequest = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
        bus.cmd_addr = 4'd4; bus.cmd_wdata = 32'h0;
        step();
        bus.cmd_valid = 1'b0;
        total++; if (av !== {1'b0, 1'b1, 4'd4, 32'h0}) begin bad++; $display("FAIL rm_av got=%h", av); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.avalon_waitrequest = 1'b0;
        total++; if (av !== 38'd0) begin bad++; $display("FAIL rm_drop got=%h exp=0", av); end
        total++; if (rs !== 34'd0) begin bad++; $display("FAIL rm_rs got=%h exp=0", rs); end
        total++; if (ctl !== 2'b10) begin bad++; $display("FAIL rm_ctl got=%b exp=10", ctl); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (rs !== 34'd0) begin bad++; $display("FAIL rm_norsp[%0d] got=%h", i, rs); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = 4'd0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        bus.avalon_readdata = 32'h0;
        bus.avalon_waitrequest = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
